// File: rtl/fp_normalizer.sv
// fp_normalizer: packs an ALU mantissa sum into an IEEE-754 single.
// It handles carry-out, cancellation to zero, overflow to infinity and
// underflow flush-to-zero, and left-shifts unnormalized sums one bit per cycle.
module fp_normalizer (
  input  logic        clock,
  input  logic        resetN,
  input  logic        inValid,
  output logic        inReady,
  input  logic        alignedSign,
  input  logic [7:0]  exponentOut,
  input  logic [23:0] alignedResult,
  input  logic        carryOut,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] Result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [8:0]  exp_q, exp_d;
  logic [23:0] mant_q, mant_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [8:0]  expInc;
  logic [8:0]  expDec;
  logic [23:0] mantShl;

  // Next-state logic: classify on accept, shift one bit per cycle in NORM and
  // go straight to DONE on the shift that brings the leading one into bit 23.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    expInc   = {1'b0, exponentOut} + 9'd1;
    expDec   = exp_q - 9'd1;
    mantShl  = {mant_q[22:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (inValid) begin
          sign_d = alignedSign;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (carryOut) begin
            mant_d  = {1'b1, alignedResult[23:1]};
            exp_d   = expInc;
            state_d = DONE;
            if (expInc >= 9'd255) begin
              result_d = {alignedSign, 8'hFF, 23'h0};
              ovf_d    = 1'b1;
            end else begin
              result_d = {alignedSign, expInc[7:0], alignedResult[23:1]};
            end
          end else if (alignedResult == 24'h0) begin
            mant_d   = 24'h0;
            exp_d    = {1'b0, exponentOut};
            result_d = 32'h0;
            state_d  = DONE;
          end else if (exponentOut == 8'h00) begin
            mant_d   = alignedResult;
            exp_d    = 9'h0;
            result_d = {alignedSign, 31'h0};
            unf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            mant_d = alignedResult;
            exp_d  = {1'b0, exponentOut};
            if (alignedResult[23]) begin
              result_d = {alignedSign, exponentOut, alignedResult[22:0]};
              state_d  = DONE;
            end else begin
              state_d = NORM;
            end
          end
        end
      end

      NORM: begin
        if (mant_q[23]) begin
          result_d = {sign_q, exp_q[7:0], mant_q[22:0]};
          state_d  = DONE;
        end else if (exp_q > 9'd1) begin
          mant_d = mantShl;
          exp_d  = expDec;
          if (mantShl[23]) begin
            result_d = {sign_q, expDec[7:0], mantShl[22:0]};
            state_d  = DONE;
          end
        end else begin
          result_d = {sign_q, 31'h0};
          unf_d    = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (outReady) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 9'h0;
      mant_q   <= 24'h0;
      result_q <= 32'h0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign inReady   = resetN && (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign Result    = result_q;
  assign overflow  = ovf_q && outValid;
  assign underflow = unf_q && outValid;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed vectors with hand-computed IEEE-754 results.
module tb_fp_normalizer;

  logic        clock;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic        alignedSign;
  logic [7:0]  exponentOut;
  logic [23:0] alignedResult;
  logic        carryOut;
  logic        outValid;
  logic        outReady;
  logic [31:0] Result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] heldResult;

  fp_normalizer dut (
    .clock         (clock),
    .resetN        (resetN),
    .inValid       (inValid),
    .inReady       (inReady),
    .alignedSign   (alignedSign),
    .exponentOut   (exponentOut),
    .alignedResult (alignedResult),
    .carryOut      (carryOut),
    .outValid      (outValid),
    .outReady      (outReady),
    .Result        (Result),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // 10 time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one operand on a falling edge and hold it through the accept edge.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
    @(negedge clock);
    alignedSign   = s;
    exponentOut   = e;
    alignedResult = m;
    carryOut      = c;
    inValid       = 1'b1;
    check("accept_inReady", {31'h0, inReady}, 32'h1);
    @(posedge clock);
    #1;
    inValid       = 1'b0;
    alignedSign   = ~s;
    exponentOut   = 8'hA5;
    alignedResult = 24'h5A5A5A;
    carryOut      = ~c;
  endtask

  // Wait (bounded) for outValid, then compare latency, Result and flags.
  task automatic checkOutput(input string tag, input logic [31:0] expRes,
                             input logic expOvf, input logic expUnf, input int expLat);
    int lat;
    lat = 1;
    while (!outValid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_valid"}, {31'h0, outValid}, 32'h1);
    check({tag, "_latency"}, lat, expLat);
    check({tag, "_result"}, Result, expRes);
    check({tag, "_overflow"}, {31'h0, overflow}, {31'h0, expOvf});
    check({tag, "_underflow"}, {31'h0, underflow}, {31'h0, expUnf});
  endtask

  task automatic handOff(input string tag);
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    check({tag, "_drop_valid"}, {31'h0, outValid}, 32'h0);
    check({tag, "_idle_ready"}, {31'h0, inReady}, 32'h1);
    check({tag, "_idle_flags"}, {30'h0, overflow, underflow}, 32'h0);
  endtask

  initial begin
    resetN        = 1'b0;
    inValid       = 1'b0;
    alignedSign   = 1'b0;
    exponentOut   = 8'h0;
    alignedResult = 24'h0;
    carryOut      = 1'b0;
    outReady      = 1'b0;

    #12;
    check("reset_inReady", {31'h0, inReady}, 32'h0);
    check("reset_outValid", {31'h0, outValid}, 32'h0);
    check("reset_Result", Result, 32'h0);
    check("reset_flags", {30'h0, overflow, underflow}, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("release_inReady", {31'h0, inReady}, 32'h1);

    applyStimulus(1'b0, 8'h7F, 24'h000000, 1'b1);
    checkOutput("carry", 32'h40000000, 1'b0, 1'b0, 1);
    handOff("carry");

    // Inputs toggle with inValid high while busy; they must be ignored.
    applyStimulus(1'b0, 8'h7F, 24'h000001, 1'b0);
    inValid = 1'b1;
    checkOutput("long", 32'h34000000, 1'b0, 1'b0, 24);
    inValid = 1'b0;
    handOff("long");

    applyStimulus(1'b1, 8'hFE, 24'h123456, 1'b1);
    checkOutput("ovf", 32'hFF800000, 1'b1, 1'b0, 1);
    heldResult = Result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("hold_result", Result, heldResult);
      check("hold_flags", {29'h0, outValid, overflow, underflow}, 32'h6);
      check("hold_inReady", {31'h0, inReady}, 32'h0);
    end
    handOff("ovf");

    applyStimulus(1'b0, 8'hFF, 24'h000000, 1'b1);
    checkOutput("ovf_ff", 32'h7F800000, 1'b1, 1'b0, 1);
    handOff("ovf_ff");

    applyStimulus(1'b1, 8'h55, 24'h000000, 1'b0);
    checkOutput("cancel", 32'h00000000, 1'b0, 1'b0, 1);
    handOff("cancel");

    applyStimulus(1'b1, 8'h03, 24'h000010, 1'b0);
    checkOutput("unf_norm", 32'h80000000, 1'b0, 1'b1, 4);
    handOff("unf_norm");

    applyStimulus(1'b1, 8'h80, 24'hC00000, 1'b0);
    checkOutput("normed", 32'hC0400000, 1'b0, 1'b0, 1);
    handOff("normed");

    applyStimulus(1'b1, 8'h00, 24'h400000, 1'b0);
    checkOutput("exp_zero", 32'h80000000, 1'b0, 1'b1, 1);
    handOff("exp_zero");

    applyStimulus(1'b0, 8'h10, 24'hFFFFFF, 1'b1);
    checkOutput("carry_trunc", 32'h08FFFFFF, 1'b0, 1'b0, 1);
    handOff("carry_trunc");

    applyStimulus(1'b0, 8'h00, 24'h000000, 1'b1);
    checkOutput("carry_prio", 32'h00800000, 1'b0, 1'b0, 1);
    handOff("carry_prio");

    applyStimulus(1'b0, 8'hFD, 24'h000002, 1'b1);
    checkOutput("carry_fd", 32'h7F000001, 1'b0, 1'b0, 1);
    handOff("carry_fd");

    applyStimulus(1'b0, 8'h85, 24'h300000, 1'b0);
    checkOutput("short", 32'h41C00000, 1'b0, 1'b0, 3);
    handOff("short");

    applyStimulus(1'b0, 8'h02, 24'h400000, 1'b0);
    checkOutput("min_norm", 32'h00800000, 1'b0, 1'b0, 2);
    handOff("min_norm");

    applyStimulus(1'b0, 8'h01, 24'h400000, 1'b0);
    checkOutput("exp_one", 32'h00000000, 1'b0, 1'b1, 2);
    handOff("exp_one");

    // Reset in the middle of a long normalization.
    applyStimulus(1'b1, 8'h7F, 24'h000001, 1'b0);
    repeat (5) @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    check("midreset_outValid", {31'h0, outValid}, 32'h0);
    check("midreset_Result", Result, 32'h0);
    check("midreset_inReady", {31'h0, inReady}, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("rerelease_inReady", {31'h0, inReady}, 32'h1);
    @(posedge clock);
    #1;
    check("rerelease_idle", {30'h0, outValid, inReady}, 32'h1);

    applyStimulus(1'b1, 8'h80, 24'hC00000, 1'b0);
    checkOutput("after_reset", 32'hC0400000, 1'b0, 1'b0, 1);
    handOff("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
